second_game_obstacle_map: RTL and testbench



---
 rtl/second_game_obstacle_map.sv | 87 ++++++++
 tb/tb_second_game_obstacle_map.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/second_game_obstacle_map.sv
// second_game_obstacle_map: scrolling LFSR-generated obstacle field answering per-pixel queries.
// Define SECOND_GAME_OBSTACLE_GAP_EN to force one free column into every generated row.
module second_game_obstacle_map #(
  parameter int SCREEN_WIDTH = 400,
  parameter int SCREEN_HEIGHT = 600,
  parameter int TILE_LOG2 = 5,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_frame_tick,
  input  logic i_run,
  input  logic [3:0] i_speed,
  input  logic [$clog2(SCREEN_WIDTH)-1:0] i_screen_x,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0] i_screen_y,
  output logic o_is_obstacle,
  output logic [15:0] o_rows_passed
);
  localparam int TILE = 1 << TILE_LOG2;
  localparam int COLS = (SCREEN_WIDTH + TILE - 1) / TILE;
  localparam int NROWS = (SCREEN_HEIGHT + TILE - 1) / TILE + 1;
  localparam int XW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT);
  localparam int HW = $clog2(NROWS);
  localparam int KW = YW + 1 - TILE_LOG2;
  localparam int SW = (HW > KW ? HW : KW) + 1;
  localparam int CW = XW - TILE_LOG2;
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
  logic [COLS-1:0] rows [NROWS];
  logic [HW-1:0] head, head_n, phys;
  logic [TILE_LOG2-1:0] s;
  logic [TILE_LOG2:0] sum;
  logic [15:0] lfsr, lfsr_n;
  logic [COLS-1:0] mask;
  logic [3:0] gap;
  logic [KW-1:0] k;
  logic [SW-1:0] hk;
  logic [CW-1:0] col;
  logic [(1<<CW)-1:0] qrow;
  logic in_range, hit;
  always_comb begin
    sum = {1'b0, s} + (TILE_LOG2+1)'(i_speed);
    head_n = (head == '0) ? HW'(NROWS - 1) : head - HW'(1);
    lfsr_n = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    gap = (lfsr_n[15:12] >= 4'(COLS)) ? lfsr_n[15:12] - 4'(COLS) : lfsr_n[15:12];
    mask = '0;
    for (int i = 0; i < COLS; i++) begin
`ifdef SECOND_GAME_OBSTACLE_GAP_EN
      mask[i] = lfsr_n[i] & lfsr_n[(i + 3) % 16] & (gap != 4'(i));
`else
      mask[i] = lfsr_n[i] & lfsr_n[(i + 3) % 16];
`endif
    end
  end
  // Logical row k covers screen rows shifted down by the scroll offset s.
  always_comb begin
    k = KW'(((YW+1)'(i_screen_y) + (YW+1)'(TILE) - (YW+1)'(s)) >> TILE_LOG2);
    hk = SW'(head) + SW'(k);
    phys = HW'((hk >= SW'(NROWS)) ? hk - SW'(NROWS) : hk);
    col = CW'(i_screen_x >> TILE_LOG2);
    qrow = (1<<CW)'(rows[phys]);
    in_range = ({1'b0, i_screen_x} < (XW+1)'(SCREEN_WIDTH)) &&
               ({1'b0, i_screen_y} < (YW+1)'(SCREEN_HEIGHT));
    hit = in_range && qrow[col];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NROWS; r++) rows[r] <= '0;
      head <= '0;
      s <= '0;
      lfsr <= SEED;
      o_is_obstacle <= 1'b0;
      o_rows_passed <= '0;
    end else begin
      o_is_obstacle <= hit;
      if (i_frame_tick && i_run) begin
        s <= sum[TILE_LOG2-1:0];
        if (sum[TILE_LOG2]) begin
          head <= head_n;
          lfsr <= lfsr_n;
          rows[head_n] <= mask;
          if (o_rows_passed != 16'hFFFF) o_rows_passed <= o_rows_passed + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_second_game_obstacle_map.sv
// tb_second_game_obstacle_map: history-based model of the scrolling obstacle field plus directed checks.
module tb_second_game_obstacle_map;
  logic clk = 0, rst = 1, ti = 0, rn = 0, obs;
  logic [3:0] spd = 0;
  logic [8:0] sx = 0;
  logic [9:0] sy = 0;
  logic [15:0] rp;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  second_game_obstacle_map dut (
    .clk(clk), .rst(rst), .i_frame_tick(ti), .i_run(rn), .i_speed(spd),
    .i_screen_x(sx), .i_screen_y(sy), .o_is_obstacle(obs), .o_rows_passed(rp)
  );
  // Model: total pixels scrolled and the list of generated rows, newest first.
  int pos;
  logic [12:0] gen[$];
  logic [15:0] m_l, m_rp;
  logic m_obs, valid = 0, pre_req = 0;
  function automatic logic [15:0] step(logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction
  function automatic logic [12:0] mk(logic [15:0] l);
    logic [12:0] m;
    int g;
    for (int i = 0; i < 13; i++) m[i] = l[i] & l[(i + 3) % 16];
`ifdef SECOND_GAME_OBSTACLE_GAP_EN
    g = int'(l[15:12]);
    if (g >= 13) g -= 13;
    m[g] = 1'b0;
`endif
    return m;
  endfunction
  function automatic logic expect_obs(int x, int y);
    int kk;
    logic [12:0] r;
    if (x >= 400 || y >= 600) return 1'b0;
    kk = (y + 32 - pos % 32) / 32;
    if (kk >= gen.size()) return 1'b0;
    r = gen[kk];
    return r[x / 32];
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      pos = 0;
      gen.delete();
      m_l = 16'hACE1;
      m_rp = 0;
      m_obs = 0;
      valid = 1;
    end else begin
      m_obs = expect_obs(int'(sx), int'(sy));
      if (ti && rn && spd != 0) begin
        if ((pos + int'(spd)) / 32 != pos / 32) begin
          m_l = step(m_l);
          gen.push_front(mk(m_l));
          if (gen.size() > 20) void'(gen.pop_back());
          if (m_rp != 16'hFFFF) m_rp++;
        end
        pos += int'(spd);
      end
      if (pre_req) m_rp = 16'hFFFE;
    end
  end
  always @(negedge clk) begin
    if (valid) begin
      chk("cyc_obs", 32'(obs), 32'(m_obs));
      chk("cyc_rows_passed", 32'(rp), 32'(m_rp));
    end
  end
  task automatic q(int x, int y, output logic r);
    @(negedge clk);
    sx = 9'(x);
    sy = 10'(y);
    @(negedge clk);
    r = obs;
  endtask
  task automatic tick(int n, int sp, logic run);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ti = 1;
      spd = 4'(sp);
      rn = run;
      @(negedge clk);
      ti = 0;
    end
  endtask
  logic r;
  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    q(100, 100, r); chk("t1_q100_100", 32'(r), 0);
    q(399, 599, r); chk("t1_q399_599", 32'(r), 0);
    chk("t1_rp", 32'(rp), 0);
    chk("model_mask_e270", 32'(mk(step(16'hACE1))), 32'h0040);
    tick(4, 8, 1);
    chk("t2_rp", 32'(rp), 1);
    q(200, 0, r); chk("t2_hidden", 32'(r), 0);
    tick(1, 8, 1);
    q(200, 0, r); chk("t3_200_0", 32'(r), 1);
    q(200, 7, r); chk("t3_200_7", 32'(r), 1);
    q(200, 8, r); chk("t3_200_8", 32'(r), 0);
    q(191, 0, r); chk("t3_191_0", 32'(r), 0);
    q(224, 0, r); chk("t3_224_0", 32'(r), 0);
    q(400, 0, r); chk("t4_x400", 32'(r), 0);
    q(0, 600, r); chk("t4_y600", 32'(r), 0);
    tick(10, 15, 0);
    tick(10, 0, 1);
    chk("t5_rp_hold", 32'(rp), 1);
    q(200, 7, r); chk("t5_s_hold_7", 32'(r), 1);
    q(200, 8, r); chk("t5_s_hold_8", 32'(r), 0);
    tick(10, 15, 1);
    chk("t5_rp_after", 32'(rp), 5);
    @(negedge clk);
    pre_req = 1;
    @(posedge clk);
    #1 force dut.o_rows_passed = 16'hFFFE;
    #1 release dut.o_rows_passed;
    @(negedge clk);
    pre_req = 0;
    chk("t5_preload", 32'(rp), 32'hFFFE);
    tick(5, 15, 1);
    chk("t5_saturate", 32'(rp), 32'hFFFF);
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      ti = i[0];
      spd = 15;
      rn = 1;
      sx = 9'($urandom_range(0, 511));
      sy = 10'($urandom_range(0, 639));
    end
    @(negedge clk);
    ti = 0;
    rst = 1;
    @(negedge clk);
    chk("t6_rst_rp", 32'(rp), 0);
    chk("t6_rst_obs", 32'(obs), 0);
    rst = 0;
    q(200, 0, r); chk("t6_empty", 32'(r), 0);
    tick(5, 8, 1);
    q(200, 0, r); chk("t6_reseed_row", 32'(r), 1);
    chk("t6_rp", 32'(rp), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
